// File: rtl/riscv_lsu.sv
// Load/store unit: turns an ALU effective address plus funct3 into one aligned,
// byte-enabled word access and returns extended load data as a one-cycle response.
module riscv_lsu #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [WORD_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  output logic                   resp_valid,
  output logic                   resp_fault,
  output logic [WORD_LENGTH-1:0] resp_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [WORD_LENGTH-1:0] mem_addr,
  output logic [3:0]             mem_be,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  input  logic                   mem_ack,
  input  logic [WORD_LENGTH-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]             state;
  logic                   we_p0;
  logic [2:0]             funct3_p0;
  logic [WORD_LENGTH-1:0] addr_p0;
  logic [WORD_LENGTH-1:0] wdata_p0;
  logic                   fault_p1;
  logic [WORD_LENGTH-1:0] rdata_p1;
  logic                   busy;
  logic                   resp;

  function automatic logic legal_op(input logic we, input logic [2:0] f3,
                                    input logic [1:0] a);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~a[0];
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [WORD_LENGTH-1:0] lane_data(input logic [2:0] f3,
                                                       input logic [WORD_LENGTH-1:0] w);
    logic [WORD_LENGTH-1:0] d;
    case (f3[1:0])
      2'b00:   d = {4{w[7:0]}};
      2'b01:   d = {2{w[15:0]}};
      default: d = w;
    endcase
    return d;
  endfunction

  // Bit 2 of funct3 selects zero extension; bits [1:0] select the width.
  function automatic logic [WORD_LENGTH-1:0] load_extract(input logic [2:0] f3,
                                                          input logic [1:0] a,
                                                          input logic [WORD_LENGTH-1:0] rd);
    logic        [WORD_LENGTH-1:0] shifted;
    logic signed [7:0]             b;
    logic signed [15:0]            h;
    logic signed [WORD_LENGTH-1:0] ext;
    shifted = rd >> {a, 3'b000};
    b       = signed'(shifted[7:0]);
    h       = signed'(shifted[15:0]);
    case (f3)
      3'b000:  ext = WORD_LENGTH'(b);
      3'b001:  ext = WORD_LENGTH'(h);
      3'b100:  ext = signed'({24'd0, shifted[7:0]});
      3'b101:  ext = signed'({16'd0, shifted[15:0]});
      default: ext = signed'(shifted);
    endcase
    return unsigned'(ext);
  endfunction

  // Stage p0: request capture and legality; stage p1: response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      we_p0     <= 1'b0;
      funct3_p0 <= 3'd0;
      addr_p0   <= '0;
      wdata_p0  <= '0;
      fault_p1  <= 1'b0;
      rdata_p1  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_p0     <= req_we;
            funct3_p0 <= req_funct3;
            addr_p0   <= req_addr;
            wdata_p0  <= req_wdata;
            if (legal_op(req_we, req_funct3, req_addr[1:0])) begin
              state <= S_BUSY;
            end else begin
              state    <= S_RESP;
              fault_p1 <= 1'b1;
              rdata_p1 <= '0;
            end
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            state    <= S_RESP;
            fault_p1 <= 1'b0;
            rdata_p1 <= we_p0 ? '0 : load_extract(funct3_p0, addr_p0[1:0], mem_rdata);
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state and captured registers only.
  assign busy       = (state == S_BUSY);
  assign resp       = (state == S_RESP);
  assign req_ready  = (state == S_IDLE);
  assign mem_req    = busy;
  assign mem_we     = busy & we_p0;
  assign mem_addr   = busy ? {addr_p0[WORD_LENGTH-1:2], 2'b00} : '0;
  assign mem_be     = busy ? byte_en(funct3_p0, addr_p0[1:0]) : 4'b0000;
  assign mem_wdata  = busy ? lane_data(funct3_p0, wdata_p0) : '0;
  assign resp_valid = resp;
  assign resp_fault = resp & fault_p1;
  assign resp_rdata = resp ? rdata_p1 : '0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed scenarios plus randomized ops against a
// byte-lane arithmetic reference model and a bench-driven memory responder.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  riscv_lsu #(.WORD_LENGTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_fault(resp_fault), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic exp_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int  n;
    logic code_ok;
    n = op_size(f3);
    if (we) code_ok = (f3 <= 3'd2);
    else    code_ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return code_ok && ((addr % n) == 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = op_size(f3);
    if (n == 4) return 4'hF;
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (op_size(f3))
      1:       return 32'(w[7:0]) * 32'h01010101;
      2:       return 32'(w[15:0]) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int unsigned sh;
    int v;
    sh = rd >> (8 * (addr % 4));
    case (f3)
      3'd0: begin v = int'(sh & 255);   if (v > 127)   v -= 256;   return 32'(v); end
      3'd1: begin v = int'(sh & 65535); if (v > 32767) v -= 65536; return 32'(v); end
      3'd4: return sh & 255;
      3'd5: return sh & 65535;
      default: return rd;
    endcase
  endfunction

  // Entered and left on a falling edge; delay = stall cycles before ack.
  task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int delay, input logic garbage);
    logic legal;
    logic [31:0] er;
    legal = exp_legal(we, f3, addr);
    er    = we ? 32'd0 : exp_load(f3, addr, rdata);
    chk({tag, ".ready"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (!legal) begin
      chk({tag, ".fvalid"}, resp_valid, 1);
      chk({tag, ".fault"}, resp_fault, 1);
      chk({tag, ".frdata"}, resp_rdata, 0);
      chk({tag, ".fmemreq"}, mem_req, 0);
      @(negedge clk);
      chk({tag, ".fvalid_off"}, resp_valid, 0);
      chk({tag, ".fready"}, req_ready, 1);
      chk({tag, ".fmemreq2"}, mem_req, 0);
    end else begin
      for (int i = 0; i <= delay; i++) begin
        chk({tag, ".memreq"}, mem_req, 1);
        chk({tag, ".we"}, mem_we, we);
        chk({tag, ".addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        chk({tag, ".be"}, mem_be, exp_be(f3, addr));
        if (we) chk({tag, ".wdata"}, mem_wdata, exp_wdata(f3, wdata));
        chk({tag, ".busyvalid"}, resp_valid, 0);
        chk({tag, ".busyready"}, req_ready, 0);
        if (i == delay) begin
          mem_ack = 1'b1; mem_rdata = rdata; req_valid = 1'b0;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
          if (garbage) begin
            req_valid = 1'b1; req_we = 1'($urandom); req_funct3 = 3'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
          end
        end
        @(negedge clk);
      end
      mem_ack = 1'b0; mem_rdata = $urandom;
      chk({tag, ".rvalid"}, resp_valid, 1);
      chk({tag, ".rfault"}, resp_fault, 0);
      chk({tag, ".rdata"}, resp_rdata, er);
      chk({tag, ".rmemreq"}, mem_req, 0);
      chk({tag, ".rmemaddr"}, mem_addr, 0);
      chk({tag, ".rmembe"}, mem_be, 0);
      chk({tag, ".rready"}, req_ready, 0);
      @(negedge clk);
      chk({tag, ".valid_off"}, resp_valid, 0);
      chk({tag, ".ready2"}, req_ready, 1);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", req_ready, 1);
    chk("rst.valid", resp_valid, 0);
    chk("rst.fault", resp_fault, 0);
    chk("rst.rdata", resp_rdata, 0);
    chk("rst.memreq", mem_req, 0);
    chk("rst.memwe", mem_we, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.be", mem_be, 0);
    chk("rst.wdata", mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op("lw",  1'b0, 3'd2, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    do_op("lb",  1'b0, 3'd0, 32'h0000_2003, 32'h0, 32'h80FF_1234, 0, 1'b0);
    do_op("lbu", 1'b0, 3'd4, 32'h0000_2003, 32'h0, 32'h80FF_1234, 1, 1'b0);
    chk("lb.model", exp_load(3'd0, 32'h2003, 32'h80FF_1234), 32'hFFFF_FF80);
    do_op("sh",  1'b1, 3'd1, 32'h0000_300A, 32'hABCD_5678, 32'h1111_2222, 0, 1'b0);
    do_op("lwmis", 1'b0, 3'd2, 32'h0000_4002, 32'h0, 32'h0, 0, 1'b0);
    do_op("sbbad", 1'b1, 3'd4, 32'h0000_4000, 32'h55, 32'h0, 0, 1'b0);
    do_op("stall", 1'b0, 3'd5, 32'h0000_5006, 32'h0, 32'h9ABC_DEF0, 5, 1'b1);

    // Reset while waiting for ack, then a late ack must be ignored.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h6000; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mrst.busy", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    chk("mrst.memreq", mem_req, 0);
    chk("mrst.valid", resp_valid, 0);
    chk("mrst.ready", req_ready, 1);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("mrst.valid2", resp_valid, 0);
    chk("mrst.memreq2", mem_req, 0);
    do_op("mrst.lw", 1'b0, 3'd2, 32'h0000_7000, 32'h0, 32'hCAFE_F00D, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      do_op("rnd", 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
            int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit downstream of the execute-stage ALU. Takes the ALU's computed effective address plus the store operand and the instruction's funct3. Runs one aligned, byte-enabled, word-wide request/acknowledge transaction on the data-memory port. Returns sign- or zero-extended load data, or a store-complete indication, to the writeback side as a one-cycle response.

## Interface
- WORD_LENGTH, 32, data/address width; only 32 is supported.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents a memory op.
- req_ready  out  1  LSU can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  effective address (ALU alu_out).
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle pulse: load data ready, store done, or fault.
- resp_fault  out  1  qualifies resp_valid: misaligned or illegal funct3; no memory access was made.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  write strobe.
- mem_addr  out  32  word address, req_addr with bits [1:0] forced to 0.
- mem_be  out  4  byte enables, bit i = byte lane [8i+7:8i].
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completes the request this cycle; mem_rdata valid when it is high.
- mem_rdata  in  32  read word.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, funct3, addr and wdata.
  - Check legality:
    - Loads allow funct3 000, 001, 010, 100, 101.
    - Stores allow 000, 001, 010.
    - Halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Legal request: go to BUSY.
  - Illegal request: go to RESP with fault=1.
- BUSY:
  - mem_req=1, with mem_we/addr/be/wdata driven from latched values and stable until ack.
  - On mem_ack: capture the load result, go to RESP.
- RESP:
  - resp_valid=1, resp_fault and resp_rdata driven from registers; next state IDLE.
- Byte enables:
  - B/BU: 0001 << addr[1:0].
  - H/HU: 0011 << addr[1:0] (addr[1:0] is 00 or 10).
  - W: 1111.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extraction (shifted = mem_rdata >> (8*addr[1:0])):
  - LB: sign-extend shifted[7:0].
  - LBU: zero-extend shifted[7:0].
  - LH: sign-extend shifted[15:0].
  - LHU: zero-extend shifted[15:0].
  - LW: whole word.
- Output defaults:
  - mem_we/mem_addr/mem_be/mem_wdata are 0 whenever mem_req=0.
  - resp_fault/resp_rdata are 0 whenever resp_valid=0.
- mem_ack while mem_req=0 is ignored.
- req_valid outside IDLE is ignored; the upstream stage must hold the request until req_ready.

## Timing
- Reset:
  - State becomes IDLE; latched registers clear to 0.
  - Outputs: req_ready=1; all other outputs 0.
- Reset mid-transaction (BUSY or RESP): next cycle is IDLE with mem_req=0 and no resp_valid. The interrupted transaction is abandoned; the memory side must tolerate a dropped request.
- Request accepted at edge T: mem_req=1 from cycle T+1.
- mem_ack sampled high in cycle A ≥ T+1:
  - mem_req=0 from A+1.
  - resp_valid=1 in cycle A+1 only.
  - req_ready=1 from A+2.
- Minimum legal-access latency (same-cycle ack): accept T → resp_valid T+2 → next accept T+3.
- Fault: accept T → resp_valid with resp_fault=1 in T+1, mem_req never asserted, req_ready=1 at T+2.
- Throughput: at most one request per 2 cycles (fault) or 3 cycles (memory access).
- Output registering:
  - All outputs are registered or decoded from state only; none depend combinationally on req_* or mem_*.

## Test plan
- Reset, then LW addr 0x1004, mem_rdata 0xDEADBEEF with ack in the first BUSY cycle:
  - mem_addr 0x1004, be 1111, we 0.
  - resp_valid 2 cycles after accept, resp_rdata 0xDEADBEEF, fault 0.
- LB/LBU at addr 0x2003, mem_rdata 0x80FF1234:
  - be 1000.
  - LB → 0xFFFFFF80; LBU → 0x00000080.
- SH addr 0x300A, wdata 0xABCD5678:
  - mem_addr 0x3008, be 1100, mem_wdata 0x56785678, we 1.
  - resp_rdata 0, fault 0.
- Misaligned LW addr 0x4002, and SB with funct3 100:
  - resp_valid+resp_fault 1 cycle after accept.
  - mem_req stays 0.
- Memory stall: ack delayed 5 cycles:
  - mem_req and all mem_* fields stable for 5 cycles.
  - Extra req_valid pulses during BUSY are ignored.
  - Exactly one resp_valid.
- Assert rst during BUSY (before ack), then ack arrives next cycle:
  - mem_req 0 after reset edge, no resp_valid, req_ready 1.
  - Next LW completes normally.
